// File: rtl/framebuffer_mem.sv
// framebuffer_mem: single-clock dual-port pixel framebuffer.
// Port A is a free-running display scan read with a fixed two-cycle latency.
// Port B is a drawing port that runs READ / WRITE / XOR / CLEAR operations
// through a small FSM. Port B is the only writer of the pixel array.
//
// Port B handshake: an operation is accepted on a rising edge where
// b_req && b_rdy. b_rdy is high only while the FSM is idle. A request made
// while b_rdy is low is dropped, not queued, so the requester holds or
// re-issues it. b_x/b_y/b_op/b_wdata are captured on the accept edge and
// may change afterwards. b_rvalid is a one-cycle pulse that marks b_rdata
// as valid for READ only. b_rdata then holds until the next READ completes.
module framebuffer_mem #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int BPP    = 1,
   parameter int XW     = 9,
   parameter int YW     = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [XW-1:0]  a_x,
   input  logic [YW-1:0]  a_y,
   output logic [BPP-1:0] a_data,
   input  logic           b_req,
   input  logic [1:0]     b_op,
   input  logic [XW-1:0]  b_x,
   input  logic [YW-1:0]  b_y,
   input  logic [BPP-1:0] b_wdata,
   output logic           b_rdy,
   output logic           b_rvalid,
   output logic [BPP-1:0] b_rdata,
   output logic [2:0]     b_state
);

   localparam int DEPTH = WIDTH * HEIGHT;
   localparam int AFW   = XW + YW + 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [XW:0]    X_LIM     = (XW+1)'(WIDTH);
   localparam logic [YW:0]    Y_LIM     = (YW+1)'(HEIGHT);
   localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_XOR   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ_WAIT = 3'd1,
      ST_READ_DONE = 3'd2,
      ST_WRITE     = 3'd3,
      ST_RMW_WAIT  = 3'd4,
      ST_RMW_WRITE = 3'd5,
      ST_CLEAR     = 3'd6
   } state_t;

   // Pixel storage; it has no reset, so contents survive a reset.
   logic [BPP-1:0] mem [DEPTH];

   // Linear address x + y*WIDTH. It is computed one bit wider than x and y
   // together, so out-of-range coordinates cannot wrap onto a valid pixel
   // before the range check gates them.
   function automatic logic [AFW-1:0] pix_addr(input logic [XW-1:0] x,
                                               input logic [YW-1:0] y);
      return AFW'(x) + AFW'(y) * AFW'(WIDTH);
   endfunction

   function automatic logic in_range(input logic [XW-1:0] x,
                                     input logic [YW-1:0] y);
      return ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);
   endfunction

   // ---------------- Port A: display scan ----------------
   logic [AFW-1:0] a_addr_full;
   logic [AW-1:0]  a_addr_q;
   logic           a_ok_q;
   logic           unused_a_hi;

   assign a_addr_full = pix_addr(a_x, a_y);
   // Upper address bits matter only through the range flag.
   assign unused_a_hi = ^a_addr_full[AFW-1:AW];

   // Two-stage scan pipeline: the address and range flag come first, then
   // the pixel (or 0 when off-screen). A write on the same edge is not yet
   // visible, so a collision returns the old data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_addr_q <= '0;
         a_ok_q   <= 1'b0;
         a_data   <= '0;
      end else begin
         a_addr_q <= a_addr_full[AW-1:0];
         a_ok_q   <= in_range(a_x, a_y);
         a_data   <= a_ok_q ? mem[a_addr_q] : '0;
      end
   end

   // ---------------- Port B: drawing FSM ----------------
   state_t         state;
   logic [AFW-1:0] b_addr_full;
   logic [AW-1:0]  op_addr;
   logic           op_ok;
   logic [BPP-1:0] op_data;
   logic [BPP-1:0] rd_word;
   logic [AW-1:0]  clr_cnt;
   logic           unused_b_hi;

   assign b_addr_full = pix_addr(b_x, b_y);
   assign unused_b_hi = ^b_addr_full[AFW-1:AW];
   assign b_rdy       = (state == ST_IDLE);
   assign b_state     = state;

   // Operation sequencing: capture the request, read old data where the op
   // needs it, publish read results, and step the clear counter. A reset
   // aborts any op in flight without touching memory.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         op_addr  <= '0;
         op_ok    <= 1'b0;
         op_data  <= '0;
         rd_word  <= '0;
         clr_cnt  <= '0;
         b_rdata  <= '0;
         b_rvalid <= 1'b0;
      end else begin
         b_rvalid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (b_req) begin
                  op_addr <= b_addr_full[AW-1:0];
                  op_ok   <= in_range(b_x, b_y);
                  op_data <= b_wdata;
                  clr_cnt <= '0;
                  case (b_op)
                     OP_READ:  state <= ST_READ_WAIT;
                     OP_WRITE: state <= ST_WRITE;
                     OP_XOR:   state <= ST_RMW_WAIT;
                     default:  state <= ST_CLEAR;
                  endcase
               end
            end
            ST_READ_WAIT: begin
               rd_word <= op_ok ? mem[op_addr] : '0;
               state   <= ST_READ_DONE;
            end
            ST_READ_DONE: begin
               b_rdata  <= rd_word;
               b_rvalid <= 1'b1;
               state    <= ST_IDLE;
            end
            ST_WRITE: begin
               state <= ST_IDLE;
            end
            ST_RMW_WAIT: begin
               rd_word <= op_ok ? mem[op_addr] : '0;
               state   <= ST_RMW_WRITE;
            end
            ST_RMW_WRITE: begin
               state <= ST_IDLE;
            end
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST_ADDR) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   logic           mem_we;
   logic [AW-1:0]  mem_waddr;
   logic [BPP-1:0] mem_wdata;

   // Write-port steering: an out-of-range WRITE or XOR performs no write.
   // CLEAR writes one word per cycle from the counter.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = op_addr;
      mem_wdata = op_data;
      case (state)
         ST_WRITE: begin
            mem_we = op_ok;
         end
         ST_RMW_WRITE: begin
            mem_we    = op_ok;
            mem_wdata = rd_word ^ op_data;
         end
         ST_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_cnt;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   // Single write port into the pixel array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_framebuffer_mem.sv
// tb_framebuffer_mem: directed bench for framebuffer_mem.
// It uses a default 320x240 instance for draw/scan behaviour and a 4x2
// instance for the full-frame CLEAR and the reset-mid-CLEAR case.
module tb_framebuffer_mem;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_XOR   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic s_reset;

   // default build signals
   logic [8:0] a_x;
   logic [7:0] a_y;
   logic       a_data;
   logic       b_req;
   logic [1:0] b_op;
   logic [8:0] b_x;
   logic [7:0] b_y;
   logic       b_wdata;
   logic       b_rdy;
   logic       b_rvalid;
   logic       b_rdata;
   logic [2:0] b_state;

   // 4x2 build signals
   logic [1:0] s_a_x;
   logic [0:0] s_a_y;
   logic       s_a_data;
   logic       s_b_req;
   logic [1:0] s_b_op;
   logic [1:0] s_b_x;
   logic [0:0] s_b_y;
   logic       s_b_wdata;
   logic       s_b_rdy;
   logic       s_b_rvalid;
   logic       s_b_rdata;
   logic [2:0] s_b_state;

   framebuffer_mem dut (
      .clk(clk), .reset(reset),
      .a_x(a_x), .a_y(a_y), .a_data(a_data),
      .b_req(b_req), .b_op(b_op), .b_x(b_x), .b_y(b_y), .b_wdata(b_wdata),
      .b_rdy(b_rdy), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_state(b_state)
   );

   framebuffer_mem #(.WIDTH(4), .HEIGHT(2), .BPP(1), .XW(2), .YW(1)) dut_s (
      .clk(clk), .reset(s_reset),
      .a_x(s_a_x), .a_y(s_a_y), .a_data(s_a_data),
      .b_req(s_b_req), .b_op(s_b_op), .b_x(s_b_x), .b_y(s_b_y), .b_wdata(s_b_wdata),
      .b_rdy(s_b_rdy), .b_rvalid(s_b_rvalid), .b_rdata(s_b_rdata), .b_state(s_b_state)
   );

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [0:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for b_rdy, present a request, and return just after the accept edge.
   task automatic b_issue(input logic [1:0] op, input logic [8:0] x, input logic [7:0] y,
                          input logic wd);
      int n = 0;
      while (b_rdy !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("b_rdy_timeout", 32'(b_rdy), 32'd1);
      b_op = op; b_x = x; b_y = y; b_wdata = wd; b_req = 1'b1;
      tick();
      b_req = 1'b0;
   endtask

   task automatic b_write(input logic [8:0] x, input logic [7:0] y, input logic wd);
      b_issue(OP_WRITE, x, y, wd);
      chk("wr_busy", 32'(b_rdy), 32'd0);
      tick();
      chk("wr_idle", 32'(b_rdy), 32'd1);
   endtask

   task automatic b_xor(input logic [8:0] x, input logic [7:0] y, input logic wd);
      b_issue(OP_XOR, x, y, wd);
      chk("xor_busy1", 32'(b_rdy), 32'd0);
      tick();
      chk("xor_busy2", 32'(b_rdy), 32'd0);
      tick();
      chk("xor_idle", 32'(b_rdy), 32'd1);
   endtask

   // READ with exact timing: b_rvalid must rise on the second edge after accept.
   task automatic b_read(input logic [8:0] x, input logic [7:0] y, input logic exp,
                         input string tag);
      logic [0:0] e;
      exp_q.push_back(exp);
      b_issue(OP_READ, x, y, 1'b0);
      chk({tag, "_rv_n0"}, 32'(b_rvalid), 32'd0);
      tick();
      chk({tag, "_rv_n1"}, 32'(b_rvalid), 32'd0);
      tick();
      chk({tag, "_rv_n2"}, 32'(b_rvalid), 32'd1);
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, 32'(b_rdata), 32'(e));
      chk({tag, "_rdy"}, 32'(b_rdy), 32'd1);
      tick();
      chk({tag, "_rv_off"}, 32'(b_rvalid), 32'd0);
      chk({tag, "_hold"}, 32'(b_rdata), 32'(e));
   endtask

   task automatic a_read(input logic [8:0] x, input logic [7:0] y, input logic exp,
                         input string tag);
      a_x = x; a_y = y;
      tick();
      tick();
      chk(tag, 32'(a_data), 32'(exp));
   endtask

   task automatic s_a_read(input int p, input logic exp);
      s_a_x = 2'(p % 4);
      s_a_y = 1'(p / 4);
      tick();
      tick();
      chk($sformatf("s_pix%0d", p), 32'(s_a_data), 32'(exp));
   endtask

   task automatic s_clear_issue(input logic wd);
      int n = 0;
      while (s_b_rdy !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("s_rdy_timeout", 32'(s_b_rdy), 32'd1);
      s_b_op = OP_CLEAR; s_b_x = 2'd0; s_b_y = 1'd0; s_b_wdata = wd; s_b_req = 1'b1;
      tick();
      s_b_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      reset = 1'b0; s_reset = 1'b0;
      a_x = '0; a_y = '0; b_req = 1'b0; b_op = OP_READ; b_x = '0; b_y = '0; b_wdata = 1'b0;
      s_a_x = '0; s_a_y = '0; s_b_req = 1'b0; s_b_op = OP_READ; s_b_x = '0; s_b_y = '0;
      s_b_wdata = 1'b0;
      repeat (3) tick();
      reset = 1'b1; s_reset = 1'b1;
      tick();

      // reset state
      chk("rst_rdy", 32'(b_rdy), 32'd1);
      chk("rst_a_data", 32'(a_data), 32'd0);
      chk("rst_rvalid", 32'(b_rvalid), 32'd0);
      chk("rst_rdata", 32'(b_rdata), 32'd0);
      chk("rst_state", 32'(b_state), 32'd0);
      chk("s_rst_rdy", 32'(s_b_rdy), 32'd1);

      // write then read back through both ports
      b_write(9'd5, 8'd3, 1'b1);
      b_read(9'd5, 8'd3, 1'b1, "rd53");
      a_read(9'd5, 8'd3, 1'b1, "a53");

      // XOR twice on a zeroed pixel
      b_write(9'd10, 8'd10, 1'b0);
      b_xor(9'd10, 8'd10, 1'b1);
      b_read(9'd10, 8'd10, 1'b1, "xor1");
      b_xor(9'd10, 8'd10, 1'b1);
      b_read(9'd10, 8'd10, 1'b0, "xor2");

      // out-of-range coordinates: (320,0) would alias (0,1) if not gated
      b_write(9'd0, 8'd1, 1'b1);
      b_write(9'd0, 8'd0, 1'b0);
      b_write(9'd320, 8'd0, 1'b0);
      b_write(9'd0, 8'd240, 1'b1);
      b_read(9'd0, 8'd1, 1'b1, "oor_keep01");
      b_read(9'd0, 8'd0, 1'b0, "oor_keep00");
      b_read(9'd320, 8'd0, 1'b0, "oor_rd");
      a_read(9'd320, 8'd0, 1'b0, "a_oor");
      a_read(9'd0, 8'd1, 1'b1, "a01");

      // same-edge A read / B write collision at (7,7)
      b_write(9'd7, 8'd7, 1'b0);
      a_x = 9'd7; a_y = 8'd7;
      b_op = OP_WRITE; b_x = 9'd7; b_y = 8'd7; b_wdata = 1'b1; b_req = 1'b1;
      tick();
      b_req = 1'b0;
      tick();
      chk("coll_old", 32'(a_data), 32'd0);
      tick();
      chk("coll_new", 32'(a_data), 32'd1);

      // full CLEAR on the 4x2 build
      s_clear_issue(1'b1);
      n = 0;
      while (s_b_rdy == 1'b0 && n < 50) begin
         n++;
         tick();
      end
      chk("clr_busy_cycles", 32'(n), 32'd8);
      for (int p = 0; p < 8; p++) s_a_read(p, 1'b1);

      // reset in the middle of a CLEAR to 0: pixels 0..2 written, rest kept
      s_clear_issue(1'b0);
      repeat (3) tick();
      chk("mid_clr_busy", 32'(s_b_rdy), 32'd0);
      s_reset = 1'b0;
      #1;
      chk("mid_clr_rst_rdy", 32'(s_b_rdy), 32'd1);
      chk("mid_clr_rst_state", 32'(s_b_state), 32'd0);
      tick();
      tick();
      s_reset = 1'b1;
      tick();
      for (int p = 0; p < 8; p++) s_a_read(p, (p < 3) ? 1'b0 : 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
